// File: rtl/regfile_writeback.sv
// Writeback sequencer: buffers execute-stage result packets and serialises them
// into one beat per cycle on the register file's 16-bit, 8-bit and flags ports.
module regfile_writeback #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [1:0]  wb_r16_cnt,
  input  logic [15:0] wb_r16_dst0,
  input  logic [15:0] wb_r16_dst1,
  input  logic [15:0] wb_r16_data0,
  input  logic [15:0] wb_r16_data1,
  input  logic        wb_r8_en,
  input  logic [7:0]  wb_r8_dst,
  input  logic [7:0]  wb_r8_data,
  input  logic        wb_flags_en,
  input  logic [7:0]  wb_flags,
  input  logic        flush,
  output logic        reg8_we,
  output logic [7:0]  reg8_dst,
  output logic [7:0]  reg8_data,
  output logic        reg16_we,
  output logic [15:0] reg16_dst,
  output logic [15:0] reg16_data,
  output logic        flags_we,
  output logic [7:0]  flags,
  output logic        busy,
  output logic        wb_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, B16_0, B16_1, B8} state_t;

  typedef struct packed {
    logic [1:0]  cnt;
    logic [15:0] dst0;
    logic [15:0] data0;
    logic [15:0] dst1;
    logic [15:0] data1;
    logic        r8_en;
    logic [7:0]  r8_dst;
    logic [7:0]  r8_data;
    logic        fl_en;
    logic [7:0]  fl;
  } pkt_t;

  pkt_t          mem [FIFO_DEPTH];
  logic [AW-1:0] head, tail, head_nx;
  logic [AW:0]   count;
  state_t        state, state_n;
  pkt_t          in_pkt, head_pkt, next_pkt, p;
  logic          accept, push, pop, fin, keep;
  logic          r8_we_n, r16_we_n, f_we_n;
  logic [15:0]   r16_dst_n, r16_data_n;

  // True when an 8-bit destination is one half of the given register pair.
  function automatic logic pair_hit(input logic [15:0] d16, input logic [7:0] d8);
    case (d16)
      16'h0007: return (d8 == 8'h01) || (d8 == 8'h02);
      16'h0008: return (d8 == 8'h03) || (d8 == 8'h04);
      16'h0009: return (d8 == 8'h05) || (d8 == 8'h06);
      default:  return 1'b0;
    endcase
  endfunction

  function automatic state_t first_beat(input pkt_t pk);
    return (pk.cnt != 2'd0) ? B16_0 : B8;
  endfunction

  assign wb_ready = (count != FULL_CNT) && !flush;
  assign busy     = (count != '0) || (state != IDLE);
  assign accept   = wb_valid && wb_ready;
  assign push     = accept && ((wb_r16_cnt != 2'd0) || wb_r8_en || wb_flags_en);
  assign head_nx  = head + AW'(1);
  assign head_pkt = mem[head];
  assign next_pkt = mem[head_nx];

  always_comb begin
    in_pkt = '{cnt: (wb_r16_cnt == 2'd3) ? 2'd2 : wb_r16_cnt,
               dst0: wb_r16_dst0, data0: wb_r16_data0,
               dst1: wb_r16_dst1, data1: wb_r16_data1,
               r8_en: wb_r8_en, r8_dst: wb_r8_dst, r8_data: wb_r8_data,
               fl_en: wb_flags_en, fl: wb_flags};
  end

  // The registered beat is chosen from next state and the packet it belongs
  // to; on a finishing edge that is the entry behind the head being popped.
  always_comb begin
    state_n = state;
    fin     = 1'b0;
    pop     = 1'b0;
    p       = head_pkt;
    case (state)
      IDLE:  if (count != '0 && !flush) state_n = first_beat(head_pkt);
      B16_0: begin
        if (head_pkt.cnt == 2'd2) state_n = B16_1;
        else if (head_pkt.r8_en && pair_hit(head_pkt.dst0, head_pkt.r8_dst)) state_n = B8;
        else fin = 1'b1;
      end
      B16_1: begin
        if (head_pkt.r8_en && pair_hit(head_pkt.dst1, head_pkt.r8_dst)) state_n = B8;
        else fin = 1'b1;
      end
      default: fin = 1'b1;
    endcase
    if (fin) begin
      pop = 1'b1;
      if (flush || count == ONE) begin
        state_n = IDLE;
      end else begin
        state_n = first_beat(next_pkt);
        p       = next_pkt;
      end
    end
    keep = (state != IDLE) && !pop;

    r8_we_n    = 1'b0;
    r16_we_n   = 1'b0;
    f_we_n     = 1'b0;
    r16_dst_n  = p.dst0;
    r16_data_n = p.data0;
    case (state_n)
      B16_0: begin
        r16_we_n = 1'b1;
        if (p.cnt == 2'd1) begin
          f_we_n  = p.fl_en;
          r8_we_n = p.r8_en && !pair_hit(p.dst0, p.r8_dst);
        end
      end
      B16_1: begin
        r16_we_n   = 1'b1;
        r16_dst_n  = p.dst1;
        r16_data_n = p.data1;
        f_we_n     = p.fl_en;
        r8_we_n    = p.r8_en && !pair_hit(p.dst1, p.r8_dst);
      end
      B8: begin
        r8_we_n = p.r8_en;
        f_we_n  = p.fl_en && (p.cnt == 2'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= in_pkt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      reg8_we    <= 1'b0;
      reg8_dst   <= '0;
      reg8_data  <= '0;
      reg16_we   <= 1'b0;
      reg16_dst  <= '0;
      reg16_data <= '0;
      flags_we   <= 1'b0;
      flags      <= '0;
      wb_err     <= 1'b0;
    end else begin
      state  <= state_n;
      wb_err <= accept && (wb_r16_cnt == 2'd3);
      head   <= pop ? head_nx : head;
      // Flush keeps only a packet whose first beat has already issued.
      if (flush) begin
        if (keep) begin
          tail  <= head_nx;
          count <= ONE;
        end else begin
          tail  <= pop ? head_nx : head;
          count <= '0;
        end
      end else begin
        tail  <= push ? tail + AW'(1) : tail;
        count <= count + (push ? ONE : '0) - (pop ? ONE : '0);
      end
      reg8_we  <= r8_we_n;
      reg16_we <= r16_we_n;
      flags_we <= f_we_n;
      if (r8_we_n) begin
        reg8_dst  <= p.r8_dst;
        reg8_data <= p.r8_data;
      end
      if (r16_we_n) begin
        reg16_dst  <= r16_dst_n;
        reg16_data <= r16_data_n;
      end
      if (f_we_n) flags <= p.fl;
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: each task drives one scenario and
// compares the captured write-port beats against hand-derived values.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic        wb_ready;
  logic [1:0]  wb_r16_cnt;
  logic [15:0] wb_r16_dst0, wb_r16_dst1, wb_r16_data0, wb_r16_data1;
  logic        wb_r8_en;
  logic [7:0]  wb_r8_dst, wb_r8_data;
  logic        wb_flags_en;
  logic [7:0]  wb_flags;
  logic        flush;
  logic        reg8_we, reg16_we, flags_we;
  logic [7:0]  reg8_dst, reg8_data, flags;
  logic [15:0] reg16_dst, reg16_data;
  logic        busy, wb_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err_seen = 0;
  int stall_seen = 0;

  typedef struct {
    int          cyc;
    logic        r16we;
    logic [15:0] d16;
    logic [15:0] v16;
    logic        r8we;
    logic [7:0]  r8d;
    logic [7:0]  r8v;
    logic        fwe;
    logic [7:0]  f;
  } beat_t;

  beat_t log_q[$];

  regfile_writeback #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_r16_cnt(wb_r16_cnt), .wb_r16_dst0(wb_r16_dst0), .wb_r16_dst1(wb_r16_dst1),
    .wb_r16_data0(wb_r16_data0), .wb_r16_data1(wb_r16_data1),
    .wb_r8_en(wb_r8_en), .wb_r8_dst(wb_r8_dst), .wb_r8_data(wb_r8_data),
    .wb_flags_en(wb_flags_en), .wb_flags(wb_flags), .flush(flush),
    .reg8_we(reg8_we), .reg8_dst(reg8_dst), .reg8_data(reg8_data),
    .reg16_we(reg16_we), .reg16_dst(reg16_dst), .reg16_data(reg16_data),
    .flags_we(flags_we), .flags(flags), .busy(busy), .wb_err(wb_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reg8_we || reg16_we || flags_we)
      log_q.push_back('{cyc, reg16_we, reg16_dst, reg16_data,
                        reg8_we, reg8_dst, reg8_data, flags_we, flags});
    if (wb_err) err_seen++;
    if (wb_valid && !wb_ready) stall_seen++;
  end

  // Fields whose strobe is low are zeroed so held values do not matter.
  function automatic logic [58:0] pk(input beat_t b);
    return {b.r16we, b.r16we ? b.d16 : 16'h0, b.r16we ? b.v16 : 16'h0,
            b.r8we, b.r8we ? b.r8d : 8'h0, b.r8we ? b.r8v : 8'h0,
            b.fwe, b.fwe ? b.f : 8'h0};
  endfunction

  task automatic send(input logic [1:0] cnt, input logic [15:0] d0, v0, d1, v1,
                      input logic r8en, input logic [7:0] r8d, r8v,
                      input logic fen, input logic [7:0] f, output int acc);
    int n = 0;
    wb_r16_cnt = cnt; wb_r16_dst0 = d0; wb_r16_data0 = v0;
    wb_r16_dst1 = d1; wb_r16_data1 = v1;
    wb_r8_en = r8en; wb_r8_dst = r8d; wb_r8_data = r8v;
    wb_flags_en = fen; wb_flags = f;
    wb_valid = 1'b1;
    #1;
    while (!wb_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!wb_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: wb_ready=%b after %0d cycles, expected 1", wb_ready, n);
      wb_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk); #1;
    acc = cyc;
    wb_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    checks++;
    if ({reg8_we, reg16_we, flags_we, busy, wb_err, wb_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_ctrl: we8/we16/wef/busy/err/ready=%b, expected 000001",
               {reg8_we, reg16_we, flags_we, busy, wb_err, wb_ready});
    end
    checks++;
    if ({reg8_dst, reg8_data, reg16_dst, reg16_data, flags} !== 56'h0) begin
      errors++;
      $display("FAIL reset_data: got %h, expected 0",
               {reg8_dst, reg8_data, reg16_dst, reg16_data, flags});
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_r8_single();
    int acc;
    logic [58:0] exp = {1'b0, 16'h0, 16'h0, 1'b1, 8'h00, 8'h12, 1'b0, 8'h00};
    log_q.delete();
    send(2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 8'h00, 8'h12, 1'b0, 8'h00, acc);
    wait_idle();
    checks++;
    if (log_q.size() != 1) begin
      errors++;
      $display("FAIL r8_single_count: got %0d beats, expected 1", log_q.size());
    end else begin
      checks++;
      if (pk(log_q[0]) !== exp || log_q[0].cyc != acc + 1) begin
        errors++;
        $display("FAIL r8_single_beat: got %h @%0d, expected %h @%0d",
                 pk(log_q[0]), log_q[0].cyc, exp, acc + 1);
      end
    end
  endtask

  task automatic test_r16_flags();
    int acc;
    logic [58:0] exp [2];
    exp = '{{1'b1, 16'h0008, 16'h1234, 1'b0, 8'h0, 8'h0, 1'b0, 8'h00},
            {1'b1, 16'h0009, 16'h5678, 1'b0, 8'h0, 8'h0, 1'b1, 8'hF0}};
    log_q.delete();
    send(2'd2, 16'h0008, 16'h1234, 16'h0009, 16'h5678, 1'b0, 8'h0, 8'h0, 1'b1, 8'hF0, acc);
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL r16_flags_busy_beat2: busy=%b, expected 1", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL r16_flags_busy_after: busy=%b, expected 0", busy);
    end
    checks++;
    if (log_q.size() != 2) begin
      errors++;
      $display("FAIL r16_flags_count: got %0d beats, expected 2", log_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (pk(log_q[i]) !== exp[i] || log_q[i].cyc != acc + 1 + i) begin
          errors++;
          $display("FAIL r16_flags_beat%0d: got %h @%0d, expected %h @%0d",
                   i, pk(log_q[i]), log_q[i].cyc, exp[i], acc + 1 + i);
        end
      end
    end
  endtask

  task automatic test_r16_r8_split();
    int acc;
    logic [58:0] exp [2];
    exp = '{{1'b1, 16'h0007, 16'hABCD, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00},
            {1'b0, 16'h0000, 16'h0000, 1'b1, 8'h02, 8'h55, 1'b0, 8'h00}};
    log_q.delete();
    send(2'd1, 16'h0007, 16'hABCD, 16'h0, 16'h0, 1'b1, 8'h02, 8'h55, 1'b0, 8'h00, acc);
    wait_idle();
    checks++;
    if (log_q.size() != 2) begin
      errors++;
      $display("FAIL split_count: got %0d beats, expected 2", log_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (pk(log_q[i]) !== exp[i] || log_q[i].cyc != acc + 1 + i) begin
          errors++;
          $display("FAIL split_beat%0d: got %h @%0d, expected %h @%0d",
                   i, pk(log_q[i]), log_q[i].cyc, exp[i], acc + 1 + i);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc, acc0, s0;
    logic [15:0] dsts [8] = '{16'h0007, 16'h0008, 16'h0009, 16'h0010,
                              16'h0007, 16'h0008, 16'h0009, 16'h0010};
    logic [15:0] vals [8] = '{16'h1000, 16'h1001, 16'h2000, 16'h2001,
                              16'h3000, 16'h3001, 16'h4000, 16'h4001};
    logic [58:0] exp;
    log_q.delete();
    s0 = stall_seen;
    acc0 = 0;
    for (int k = 0; k < 4; k++) begin
      send(2'd2, dsts[2*k], vals[2*k], dsts[2*k+1], vals[2*k+1],
           1'b0, 8'h0, 8'h0, 1'b0, 8'h0, acc);
      if (k == 0) acc0 = acc;
    end
    wait_idle();
    checks++;
    if (stall_seen - s0 != 3) begin
      errors++;
      $display("FAIL b2b_stalls: got %0d stalled cycles, expected 3", stall_seen - s0);
    end
    checks++;
    if (log_q.size() != 8) begin
      errors++;
      $display("FAIL b2b_count: got %0d beats, expected 8", log_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        exp = {1'b1, dsts[i], vals[i], 1'b0, 8'h0, 8'h0, 1'b0, 8'h0};
        checks++;
        if (pk(log_q[i]) !== exp || log_q[i].cyc != acc0 + 1 + i) begin
          errors++;
          $display("FAIL b2b_beat%0d: got %h @%0d, expected %h @%0d",
                   i, pk(log_q[i]), log_q[i].cyc, exp, acc0 + 1 + i);
        end
      end
    end
  endtask

  task automatic test_flush();
    int acc0, acc1;
    logic [58:0] exp [2];
    exp = '{{1'b1, 16'h0007, 16'h1111, 1'b0, 8'h0, 8'h0, 1'b0, 8'h0},
            {1'b1, 16'h0008, 16'h2222, 1'b0, 8'h0, 8'h0, 1'b0, 8'h0}};
    log_q.delete();
    send(2'd2, 16'h0007, 16'h1111, 16'h0008, 16'h2222, 1'b0, 8'h0, 8'h0, 1'b0, 8'h0, acc0);
    send(2'd1, 16'h0009, 16'h3333, 16'h0, 16'h0, 1'b0, 8'h0, 8'h0, 1'b0, 8'h0, acc1);
    flush = 1'b1;
    #1;
    checks++;
    if (wb_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: wb_ready=%b, expected 0", wb_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);
    checks++;
    if (log_q.size() != 2) begin
      errors++;
      $display("FAIL flush_count: got %0d beats, expected 2", log_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (pk(log_q[i]) !== exp[i] || log_q[i].cyc != acc0 + 1 + i) begin
          errors++;
          $display("FAIL flush_beat%0d: got %h @%0d, expected %h @%0d",
                   i, pk(log_q[i]), log_q[i].cyc, exp[i], acc0 + 1 + i);
        end
      end
    end
  endtask

  task automatic test_illegal_cnt();
    int acc, e0;
    logic [58:0] exp [2];
    exp = '{{1'b1, 16'h0007, 16'hAAAA, 1'b0, 8'h0, 8'h0, 1'b0, 8'h0},
            {1'b1, 16'h0009, 16'hBBBB, 1'b0, 8'h0, 8'h0, 1'b0, 8'h0}};
    log_q.delete();
    e0 = err_seen;
    send(2'd3, 16'h0007, 16'hAAAA, 16'h0009, 16'hBBBB, 1'b0, 8'h0, 8'h0, 1'b0, 8'h0, acc);
    @(negedge clk);
    checks++;
    if (wb_err !== 1'b1) begin
      errors++;
      $display("FAIL illegal_err_pulse: wb_err=%b, expected 1", wb_err);
    end
    wait_idle();
    checks++;
    if (err_seen - e0 != 1) begin
      errors++;
      $display("FAIL illegal_err_count: got %0d pulses, expected 1", err_seen - e0);
    end
    checks++;
    if (log_q.size() != 2) begin
      errors++;
      $display("FAIL illegal_count: got %0d beats, expected 2", log_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (pk(log_q[i]) !== exp[i] || log_q[i].cyc != acc + 1 + i) begin
          errors++;
          $display("FAIL illegal_beat%0d: got %h @%0d, expected %h @%0d",
                   i, pk(log_q[i]), log_q[i].cyc, exp[i], acc + 1 + i);
        end
      end
    end
  endtask

  task automatic test_empty_packet();
    int acc, e0;
    log_q.delete();
    e0 = err_seen;
    send(2'd0, 16'h0007, 16'h9999, 16'h0, 16'h0, 1'b0, 8'h01, 8'h77, 1'b0, 8'hFF, acc);
    repeat (5) @(negedge clk);
    checks++;
    if (log_q.size() != 0 || busy !== 1'b0 || err_seen != e0) begin
      errors++;
      $display("FAIL empty_packet: beats=%0d busy=%b errs=%0d, expected 0 0 0",
               log_q.size(), busy, err_seen - e0);
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    send(2'd2, 16'h0008, 16'hCAFE, 16'h0009, 16'hBEEF, 1'b0, 8'h0, 8'h0, 1'b1, 8'h5A, acc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (reg16_we !== 1'b1 || reg16_dst !== 16'h0009) begin
      errors++;
      $display("FAIL rst_mid_in_b16_1: we=%b dst=%h, expected 1 0009", reg16_we, reg16_dst);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({reg8_we, reg16_we, flags_we, busy, wb_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL rst_mid_ctrl: we8/we16/wef/busy/ready=%b, expected 00001",
               {reg8_we, reg16_we, flags_we, busy, wb_ready});
    end
    checks++;
    if ({reg16_dst, reg16_data, flags, reg8_dst, reg8_data} !== 56'h0) begin
      errors++;
      $display("FAIL rst_mid_data: got %h, expected 0",
               {reg16_dst, reg16_data, flags, reg8_dst, reg8_data});
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    log_q.delete();
    repeat (6) @(negedge clk);
    checks++;
    if (log_q.size() != 0 || wb_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_after: beats=%0d ready=%b, expected 0 1", log_q.size(), wb_ready);
    end
  endtask

  initial begin
    wb_valid = 1'b0; flush = 1'b0;
    wb_r16_cnt = 2'd0; wb_r16_dst0 = '0; wb_r16_dst1 = '0;
    wb_r16_data0 = '0; wb_r16_data1 = '0;
    wb_r8_en = 1'b0; wb_r8_dst = '0; wb_r8_data = '0;
    wb_flags_en = 1'b0; wb_flags = '0;
    test_reset();
    test_r8_single();
    test_r16_flags();
    test_r16_r8_split();
    test_back_to_back();
    test_flush();
    test_illegal_cnt();
    test_empty_packet();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
